// File: rtl/buffer_reader.sv
// buffer_reader: a DEPTH-entry word FIFO with a registered request/acknowledge
// read port. The entry currently offered on DataO is held outside the queue, so
// Count, Full and Empty describe only the words still waiting behind it.
//
// Optional build macro: BUFFER_READER_PARITY_EN adds the ParityO output.
//
// Ports:
//   ref_clk   in   clock; all state changes on the rising edge
//   rst_n     in   asynchronous active-low reset
//   WE        in   producer push strobe
//   DataI     in   [31:0] producer data
//   Flush     in   synchronous discard of queued and in-flight data
//   MemAck    in   consumer acknowledge of the current request
//   MemReq    out  registered request valid
//   DataO     out  [31:0] registered request data, stable while MemReq=1
//   Full      out  queue holds DEPTH entries
//   Empty     out  queue holds no entries
//   Count     out  [$clog2(DEPTH):0] queued entries, excluding DataO
//   Overflow  out  sticky: a push was dropped while Full
//   ParityO   out  XOR of DataO (BUFFER_READER_PARITY_EN only)
module buffer_reader #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       ref_clk,
  input  logic                       rst_n,
  input  logic                       WE,
  input  logic [31:0]                DataI,
  input  logic                       Flush,
  input  logic                       MemAck,
  output logic                       MemReq,
  output logic [31:0]                DataO,
  output logic                       Full,
  output logic                       Empty,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Overflow
`ifdef BUFFER_READER_PARITY_EN
  ,
  output logic                       ParityO
`endif
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                req_q, req_d;
  logic                full_q, empty_q;
  logic                ovf_q, ovf_d;
  logic                push, pop;
`ifdef BUFFER_READER_PARITY_EN
  logic                parity_q;
`endif

  // Next-state, pointer and count logic
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    pop     = 1'b0;

    if (Flush) begin
      // Flush wins over WE and MemAck; DataO keeps its last value but is no longer requested
      state_d = IDLE;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // A pop this cycle never frees room for a push: acceptance uses the registered Full
      push = WE && !full_q;
      if (WE && full_q) begin
        ovf_d = 1'b1;
      end

      unique case (state_q)
        IDLE: pop = (count_q != '0);
        REQ: begin
          if (MemAck) begin
            if (count_q != '0) begin
              pop = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: ;
      endcase

      if (pop) begin
        data_d  = mem_q[head_q];
        head_d  = head_q + PTR_W'(1);
        state_d = REQ;
      end
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    req_d = (state_d == REQ);
  end

  // State and output registers
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      data_q   <= '0;
      req_q    <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
`ifdef BUFFER_READER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      data_q   <= data_d;
      req_q    <= req_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == '0);
      ovf_q    <= ovf_d;
`ifdef BUFFER_READER_PARITY_EN
      parity_q <= ^data_d;
`endif
    end
  end

  // Storage array; contents are meaningless outside head..tail so no reset
  always_ff @(posedge ref_clk) begin
    if (push) begin
      mem_q[tail_q] <= DataI;
    end
  end

  assign MemReq   = req_q;
  assign DataO    = data_q;
  assign Full     = full_q;
  assign Empty    = empty_q;
  assign Count    = count_q;
  assign Overflow = ovf_q;
`ifdef BUFFER_READER_PARITY_EN
  assign ParityO  = parity_q;
`endif

endmodule

// File: tb/tb_buffer_reader.sv
// Directed bench for buffer_reader (DEPTH=4): latency, back-to-back transfer,
// overflow, hold under back-pressure, flush and mid-transfer reset.
module tb_buffer_reader;

  logic        ref_clk = 1'b0;
  logic        rst_n;
  logic        WE;
  logic [31:0] DataI;
  logic        Flush;
  logic        MemAck;
  logic        MemReq;
  logic [31:0] DataO;
  logic        Full;
  logic        Empty;
  logic [2:0]  Count;
  logic        Overflow;
`ifdef BUFFER_READER_PARITY_EN
  logic        ParityO;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  buffer_reader #(.DEPTH(4)) dut (
    .ref_clk  (ref_clk),
    .rst_n    (rst_n),
    .WE       (WE),
    .DataI    (DataI),
    .Flush    (Flush),
    .MemAck   (MemAck),
    .MemReq   (MemReq),
    .DataO    (DataO),
    .Full     (Full),
    .Empty    (Empty),
    .Count    (Count),
    .Overflow (Overflow)
`ifdef BUFFER_READER_PARITY_EN
    ,
    .ParityO  (ParityO)
`endif
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   32'(MemReq),   32'd0);
    check({tag, "_data"},  DataO,         32'd0);
    check({tag, "_count"}, 32'(Count),    32'd0);
    check({tag, "_empty"}, 32'(Empty),    32'd1);
    check({tag, "_full"},  32'(Full),     32'd0);
    check({tag, "_ovf"},   32'(Overflow), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    WE     = 1'b0;
    DataI  = '0;
    Flush  = 1'b0;
    MemAck = 1'b0;
    #12;
    check_reset_values("rst");
    rst_n = 1'b1;

    // Single word: push at edge 1, requested after edge 2, released after edge 3
    WE = 1'b1; DataI = 32'h0000_07FF; MemAck = 1'b1;
    step();
    WE = 1'b0;
    check("lat_e1_req",   32'(MemReq), 32'd0);
    check("lat_e1_count", 32'(Count),  32'd1);
    step();
    check("lat_e2_req",   32'(MemReq), 32'd1);
    check("lat_e2_data",  DataO,       32'h0000_07FF);
    check("lat_e2_count", 32'(Count),  32'd0);
    step();
    check("lat_e3_req",   32'(MemReq), 32'd0);
    check("lat_e3_empty", 32'(Empty),  32'd1);

    // Back-to-back: 0,1,2 with MemAck held high
    WE = 1'b1; DataI = 32'd0;
    step();
    DataI = 32'd1;
    check("b2b_e1_req", 32'(MemReq), 32'd0);
    step();
    DataI = 32'd2;
    check("b2b_d0_req",   32'(MemReq), 32'd1);
    check("b2b_d0_data",  DataO,       32'd0);
    check("b2b_d0_count", 32'(Count),  32'd1);
    step();
    WE = 1'b0;
    check("b2b_d1_data",  DataO,       32'd1);
    check("b2b_d1_count", 32'(Count),  32'd1);
    step();
    check("b2b_d2_req",   32'(MemReq), 32'd1);
    check("b2b_d2_data",  DataO,       32'd2);
    check("b2b_d2_count", 32'(Count),  32'd0);
    step();
    check("b2b_idle_req",   32'(MemReq), 32'd0);
    check("b2b_idle_empty", 32'(Empty),  32'd1);

    // Overflow: six pushes 0x10..0x15 without acknowledge
    MemAck = 1'b0;
    WE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      DataI = 32'h10 + 32'(i);
      step();
    end
    WE = 1'b0;
    check("ovf_req",   32'(MemReq),   32'd1);
    check("ovf_data",  DataO,         32'h10);
    check("ovf_count", 32'(Count),    32'd4);
    check("ovf_full",  32'(Full),     32'd1);
    check("ovf_flag",  32'(Overflow), 32'd1);

    // Back-pressure: request held for five cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_req",   32'(MemReq), 32'd1);
      check("hold_data",  DataO,       32'h10);
      check("hold_count", 32'(Count),  32'd4);
    end

    // Drain the four queued words; 0x15 must never appear
    MemAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_data",  DataO,      32'h11 + 32'(i));
      check("drain_count", 32'(Count), 32'(3 - i));
      check("drain_full",  32'(Full),  32'd0);
    end
    step();
    check("drain_idle_req", 32'(MemReq),   32'd0);
    check("drain_empty",    32'(Empty),    32'd1);
    check("ovf_sticky",     32'(Overflow), 32'd1);

    // Flush with three queued words, WE and MemAck also high
    MemAck = 1'b0;
    WE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      DataI = 32'h20 + 32'(i);
      step();
    end
    check("pre_flush_data",  DataO,      32'h20);
    check("pre_flush_count", 32'(Count), 32'd3);
    Flush = 1'b1; MemAck = 1'b1; DataI = 32'h99;
    step();
    Flush = 1'b0; WE = 1'b0;
    check("flush_req",   32'(MemReq),   32'd0);
    check("flush_count", 32'(Count),    32'd0);
    check("flush_empty", 32'(Empty),    32'd1);
    check("flush_ovf",   32'(Overflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_flush_req", 32'(MemReq), 32'd0);
    end

    // Reset in REQ with two words queued
    MemAck = 1'b0;
    WE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      DataI = 32'h30 + 32'(i);
      step();
    end
    WE = 1'b0;
    check("pre_rst_req",   32'(MemReq), 32'd1);
    check("pre_rst_data",  DataO,       32'h30);
    check("pre_rst_count", 32'(Count),  32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    #2;
    rst_n = 1'b1;
    MemAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_req",   32'(MemReq), 32'd0);
      check("post_rst_count", 32'(Count),  32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
